// File: rtl/recip_share_arbiter.sv
// recip_share_arbiter: round-robin sequencer sharing one multi-cycle reciprocal unit
// among NUM_REQ softmax row engines. One operation is in flight at a time.
// Optional build macro RECIP_ZERO_GUARD_EN: X <= 0 is answered locally with a
// saturated error result and never reaches the unit.

module recip_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         ru_x_in,
  output logic                      ru_valid_in,
  input  logic [DATA_W-1:0]         ru_recip_out,
  input  logic                      ru_valid_out,
  output logic                      busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [DATA_W-1:0] SAT_VAL = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]    ru_x_in_q, ru_x_in_d;
  logic                 ru_valid_in_q, ru_valid_in_d;
  logic                 busy_q, busy_d;

  logic                 grant_vld_c;
  logic [PTR_W-1:0]     grant_idx_c;
  logic [PTR_W-1:0]     scan_idx_c;
  logic [NUM_REQ-1:0]   grant_oh_c;
  logic [DATA_W-1:0]    grant_data_c;
  logic [PTR_W-1:0]     next_ptr_c;
  logic [NUM_REQ-1:0]   owner_oh_c;
  logic [CNT_W-1:0]     cnt_inc_c;

  // Rotating-priority grant: first valid requester at or above rr_ptr, modulo NUM_REQ
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    scan_idx_c  = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      scan_idx_c = PTR_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (req_valid[scan_idx_c]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = scan_idx_c;
      end
    end
  end

  // Granted requester's data, one-hot grant and pointer advance past the winner
  always_comb begin
    grant_data_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx_c == PTR_W'(i)) begin
        grant_data_c = req_data[i*DATA_W +: DATA_W];
      end
    end
    grant_oh_c = NUM_REQ'(1) << grant_idx_c;
    owner_oh_c = NUM_REQ'(1) << owner_q;
    next_ptr_c = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    cnt_inc_c  = cnt_q + CNT_W'(1);
  end

  // Accept is offered only while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == ST_IDLE) && grant_vld_c) begin
      req_ready = grant_oh_c;
    end
  end

`ifdef RECIP_ZERO_GUARD_EN
  logic x_nonpos_c;

  // Non-positive sums have no meaningful reciprocal; flag them before issue
  always_comb begin
    x_nonpos_c = grant_data_c[DATA_W-1] | (grant_data_c == '0);
  end
`endif

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    ru_x_in_d     = ru_x_in_q;
    ru_valid_in_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld_c) begin
          owner_d  = grant_idx_c;
          rr_ptr_d = next_ptr_c;
`ifdef RECIP_ZERO_GUARD_EN
          if (x_nonpos_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = grant_oh_c;
            rsp_data_d  = SAT_VAL;
            rsp_err_d   = 1'b1;
          end else begin
            state_d       = ST_ISSUE;
            ru_valid_in_d = 1'b1;
            ru_x_in_d     = grant_data_c;
          end
`else
          state_d       = ST_ISSUE;
          ru_valid_in_d = 1'b1;
          ru_x_in_d     = grant_data_c;
`endif
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A real result in the timeout cycle takes priority over the abort
        if (ru_valid_out) begin
          state_d     = ST_RESP;
          rsp_valid_d = owner_oh_c;
          rsp_data_d  = ru_recip_out;
          rsp_err_d   = 1'b0;
        end else if (cnt_inc_c == CNT_W'(TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = owner_oh_c;
          rsp_data_d  = SAT_VAL;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      ru_x_in_q     <= '0;
      ru_valid_in_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      ru_x_in_q     <= ru_x_in_d;
      ru_valid_in_q <= ru_valid_in_d;
      busy_q        <= busy_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign ru_x_in     = ru_x_in_q;
  assign ru_valid_in = ru_valid_in_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_recip_share_arbiter.sv
// Bench for recip_share_arbiter: reciprocal-unit stub with programmable latency,
// scoreboard of expected responses keyed to the cycle they must appear.
// Honours RECIP_ZERO_GUARD_EN for the X <= 0 expectations.

module tb_recip_share_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [DATA_W-1:0] SAT = 24'h7FFFFF;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [DATA_W-1:0]         ru_x_in;
  logic                      ru_valid_in;
  logic [DATA_W-1:0]         ru_recip_out;
  logic                      ru_valid_out;
  logic                      busy;

  recip_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ru_x_in(ru_x_in), .ru_valid_in(ru_valid_in),
    .ru_recip_out(ru_recip_out), .ru_valid_out(ru_valid_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reciprocal unit stub: 2^14/X in S13.10 is 2^24/raw(X)
  int stub_lat = 26;
  bit stub_en  = 1'b1;
  bit spur     = 1'b0;
  logic        stub_busy;
  int          stub_cnt;
  logic [DATA_W-1:0] stub_res;

  function automatic logic [DATA_W-1:0] recip_model(input logic [DATA_W-1:0] x);
    longint unsigned q;
    if (x[DATA_W-1] || x == '0) return SAT;
    q = 64'h0100_0000 / 64'(x);
    return DATA_W'(q);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy    <= 1'b0;
      stub_cnt     <= 0;
      stub_res     <= '0;
      ru_valid_out <= 1'b0;
      ru_recip_out <= '0;
    end else begin
      ru_valid_out <= spur;
      if (stub_busy) begin
        if (stub_cnt <= 1) begin
          ru_valid_out <= 1'b1;
          ru_recip_out <= stub_res;
          stub_busy    <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
      if (ru_valid_in && stub_en) begin
        stub_busy <= 1'b1;
        stub_cnt  <= stub_lat - 1;
        stub_res  <= recip_model(ru_x_in);
      end
    end
  end

  // Scoreboard
  typedef struct {
    int                owner;
    logic [DATA_W-1:0] data;
    logic              err;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   exp_grant[$];

  logic [DATA_W-1:0] p_res   [NUM_REQ];
  logic              p_err   [NUM_REQ];
  int                p_off   [NUM_REQ];
  bit                p_issue [NUM_REQ];

  bit                issue_pending = 1'b0;
  int                issue_neg     = 0;
  logic [DATA_W-1:0] issue_x       = '0;
  logic [NUM_REQ-1:0] drop         = '0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Offer a request; off = cycles from transfer-edge negedge to response negedge minus one
  task automatic present(input int i, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] res,
                         input logic err, input int off, input bit issue);
    req_data[i*DATA_W +: DATA_W] = x;
    p_res[i]   = res;
    p_err[i]   = err;
    p_off[i]   = off;
    p_issue[i] = issue;
    req_valid[i] = 1'b1;
  endtask

  // One clock: predict any transfer at the coming edge, then check outputs after it
  task automatic tick();
    int idx;
    int eg;
    exp_t e;
    logic [NUM_REQ-1:0] exp_rv;
    bit exp_iv;
    #1;
    if (req_ready != '0) begin
      idx = -1;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (req_ready[i]) idx = i;
      chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
      chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
      eg = (exp_grant.size() > 0) ? exp_grant.pop_front() : -1;
      chk("grant_owner", 32'(idx), 32'(eg));
      e.owner = idx;
      e.data  = p_res[idx];
      e.err   = p_err[idx];
      e.cyc   = cyc + 1 + p_off[idx];
      sb.push_back(e);
      if (p_issue[idx]) begin
        issue_pending = 1'b1;
        issue_neg     = cyc + 1;
        issue_x       = req_data[idx*DATA_W +: DATA_W];
      end
      drop[idx] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = req_valid & ~drop;
    drop = '0;
    #1;
    exp_iv = issue_pending && (cyc == issue_neg);
    chk("ru_valid_in", 32'(ru_valid_in), 32'(exp_iv));
    if (exp_iv) begin
      chk("ru_x_in", 32'(ru_x_in), 32'(issue_x));
      issue_pending = 1'b0;
    end else if (issue_pending && cyc > issue_neg) begin
      issue_pending = 1'b0;
    end
    exp_rv = '0;
    if (sb.size() > 0 && sb[0].cyc == cyc) exp_rv = NUM_REQ'(1) << sb[0].owner;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv != '0) begin
      chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
      chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
      void'(sb.pop_front());
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      void'(sb.pop_front());
    end
  endtask

  // Run until every offered request has been answered, within a cycle budget
  task automatic drain(input int max);
    int n;
    n = 0;
    while ((sb.size() > 0 || req_valid != '0 || issue_pending) && n < max) begin
      tick();
      n++;
    end
    chk("drain_complete", 32'(sb.size() == 0 && req_valid == '0), 32'd1);
    tick();
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_ru_x_in"}, 32'(ru_x_in), 32'd0);
    chk({tag, "_ru_valid_in"}, 32'(ru_valid_in), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Single request, 1.0 -> 0x004000, L = 26
    exp_grant.push_back(0);
    present(0, 24'h000400, 24'h004000, 1'b0, 27, 1'b1);
    drain(200);

    // Bring the pointer back to 0 via requester 3 (4.0 -> 0x001000)
    exp_grant.push_back(3);
    present(3, 24'h001000, 24'h001000, 1'b0, 27, 1'b1);
    drain(200);

    // All four at once: 1.0, 2.0, 32.0, 0.5
    exp_grant.push_back(0); exp_grant.push_back(1);
    exp_grant.push_back(2); exp_grant.push_back(3);
    present(0, 24'h000400, 24'h004000, 1'b0, 27, 1'b1);
    present(1, 24'h000800, 24'h002000, 1'b0, 27, 1'b1);
    present(2, 24'h008000, 24'h000200, 1'b0, 27, 1'b1);
    present(3, 24'h000200, 24'h008000, 1'b0, 27, 1'b1);
    drain(400);

    // Fairness: after 2 is granted, 3 beats 1
    exp_grant.push_back(2); exp_grant.push_back(3); exp_grant.push_back(1);
    present(2, 24'h000400, 24'h004000, 1'b0, 27, 1'b1);
    tick();
    present(1, 24'h000800, 24'h002000, 1'b0, 27, 1'b1);
    present(3, 24'h008000, 24'h000200, 1'b0, 27, 1'b1);
    drain(400);

    // Stray ru_valid_out while idle must not produce a response
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Watchdog: unit never answers
    stub_en = 1'b0;
    exp_grant.push_back(3);
    present(3, 24'h000400, SAT, 1'b1, int'(TIMEOUT), 1'b1);
    drain(200);
    stub_en = 1'b1;

    // Normal service after a timeout
    exp_grant.push_back(0);
    present(0, 24'h000800, 24'h002000, 1'b0, 27, 1'b1);
    drain(200);

    // Result arrives in the timeout cycle: real result wins
    stub_lat = int'(TIMEOUT) - 1;
    exp_grant.push_back(1);
    present(1, 24'h000800, 24'h002000, 1'b0, int'(TIMEOUT), 1'b1);
    drain(200);

    // Result one cycle too late: timeout, late strobe ignored
    stub_lat = int'(TIMEOUT);
    exp_grant.push_back(2);
    present(2, 24'h000400, SAT, 1'b1, int'(TIMEOUT), 1'b1);
    drain(200);
    stub_lat = 26;

    // Zero and negative inputs
`ifdef RECIP_ZERO_GUARD_EN
    exp_grant.push_back(1);
    present(1, 24'h000000, SAT, 1'b1, 0, 1'b0);
    drain(100);
    exp_grant.push_back(0);
    present(0, 24'hFFFC00, SAT, 1'b1, 0, 1'b0);
    drain(100);
`else
    exp_grant.push_back(1);
    present(1, 24'h000000, SAT, 1'b0, 27, 1'b1);
    drain(200);
    exp_grant.push_back(0);
    present(0, 24'hFFFC00, SAT, 1'b0, 27, 1'b1);
    drain(200);
`endif

    // Reset during WAIT: operation lost, pointer back to 0
    exp_grant.push_back(1);
    present(1, 24'h000400, 24'h004000, 1'b0, 27, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) tick();
    chk("wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    present(2, 24'h000800, 24'h002000, 1'b0, 27, 1'b1);
    #1;
    chk_reset_outputs("midreset");
    sb.delete();
    exp_grant.delete();
    issue_pending = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    chk_reset_outputs("heldreset");
    present(0, 24'h000200, 24'h008000, 1'b0, 27, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_grant.push_back(0); exp_grant.push_back(2);
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
